data_mem_responder: RTL and testbench

Responder end of the core's data-memory port. It decodes `memwrite`, `aluout` and `writedata` driven by `mips` and returns `readdata` in the same cycle, as the single-cycle core requires. Low addresses are a byte-lane-writable word RAM. The 0xFFFF_xxxx region holds memory-mapped I/O: a console transmit FIFO with a valid/ready drain port and a free-running cycle counter.

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: byte-lane word RAM plus
// MMIO console TX FIFO (valid/ready drain) and a loadable free-running cycle counter.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_q, cyc_d;

  logic [AW-1:0] idx;
  logic [15:0]   off;
  logic          is_mmio, wr, ram_we;
  logic          sel_tx, sel_st, sel_cyc;
  logic          full, empty, pop, push_req, push_ok;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [7:0]    occ;

  assign idx     = aluout[AW+1:2];
  assign off     = aluout[15:0];
  assign is_mmio = (aluout[31:16] == 16'hFFFF);
  // Stores presented during reset must not touch any state.
  assign wr      = (memwrite != 2'b00) && !reset;
  assign ram_we  = wr && !is_mmio;
  assign sel_tx  = is_mmio && (off == 16'h0000);
  assign sel_st  = is_mmio && (off == 16'h0004);
  assign sel_cyc = is_mmio && (off == 16'h0008);

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : fifo_q[rd_ptr_q];
  assign pop      = tx_valid && tx_ready;
  assign push_req = wr && sel_tx;
  assign push_ok  = push_req && (!full || pop);
  assign occ      = 8'(count_q);

  always_comb begin
    be = '0;
    wd = '0;
    unique case (memwrite)
      2'b01: begin
        be = '1;
        wd = writedata;
      end
      2'b10: begin
        be = aluout[1] ? 4'b1100 : 4'b0011;
        wd = {2{writedata[15:0]}};
      end
      2'b11: begin
        be = 4'b0001 << aluout[1:0];
        wd = {4{writedata[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= writedata[7:0];
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cyc_d    = cyc_q + 32'd1;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
    if (push_req && !push_ok)          ovf_d = 1'b1;
    if (wr && sel_st && writedata[2])  ovf_d = 1'b0;
    if (wr && sel_cyc)                 cyc_d = writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      unique case (off)
        16'h0004: readdata = {16'h0000, occ, 5'b00000, ovf_q, empty, full};
        16'h0008: readdata = cyc_q;
        default:  readdata = '0;
      endcase
    end else begin
      readdata = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: expected values are queued as stimulus
// is driven and popped when the DUT output is compared.
module tb_data_mem_responder;

  localparam int unsigned FD = 8;
  localparam logic [31:0] A_TX  = 32'hFFFF_0000;
  localparam logic [31:0] A_ST  = 32'hFFFF_0004;
  localparam logic [31:0] A_CYC = 32'hFFFF_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  memwrite;
  logic [31:0] aluout, writedata, readdata;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  txq [$];
  logic        m_ovf;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    aluout    = a;
    writedata = d;
    #1;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    drive(2'b00, a, 32'h0);
    expect_val(e);
    chk(tag, readdata);
  endtask

  function automatic logic [31:0] st_exp();
    logic [31:0] r;
    int unsigned n;
    n = txq.size();
    r = '0;
    r[0] = (n == FD);
    r[1] = (n == 0);
    r[2] = m_ovf;
    r[15:8] = 8'(n);
    return r;
  endfunction

  task automatic tx_store(input logic [7:0] d);
    logic popping;
    popping = tx_ready && (txq.size() != 0);
    drive(2'b11, A_TX, {24'hFFFFFF, d});
    expect_val(32'h0);
    chk("txdata_read", readdata);
    if (popping) begin
      expect_val({24'h0, txq.pop_front()});
      chk("tx_pop_data", {24'h0, tx_data});
    end
    if (txq.size() < FD) txq.push_back(d);
    else m_ovf = 1'b1;
    tick();
  endtask

  task automatic drain(input int unsigned n);
    tx_ready = 1'b1;
    drive(2'b00, 32'h0, 32'h0);
    for (int unsigned k = 0; k < n; k++) begin
      expect_val(32'h1);
      chk("tx_valid", {31'h0, tx_valid});
      expect_val({24'h0, txq.pop_front()});
      chk("tx_data", {24'h0, tx_data});
      tick();
    end
    tx_ready = 1'b0;
    #1;
    expect_val({31'h0, txq.size() != 0});
    chk("tx_valid_after_drain", {31'h0, tx_valid});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; memwrite = 2'b00; aluout = '0; writedata = '0;
    tx_ready = 1'b0; m_ovf = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rd("rst_status", A_ST, 32'h0000_0002);
    rd("rst_cycle", A_CYC, 32'h0);
    expect_val(32'h0); chk("rst_tx_valid", {31'h0, tx_valid});
    expect_val(32'h0); chk("rst_tx_data", {24'h0, tx_data});
    rd("mmio_hole", 32'hFFFF_000C, 32'h0);
    tick();
    rd("cycle_inc", A_CYC, 32'h1);

    // Word / half / byte stores
    drive(2'b01, 32'h10, 32'h1122_3344); tick();
    drive(2'b10, 32'h12, 32'hFFFF_AABB);
    expect_val(32'h1122_3344); chk("sh_cycle_old", readdata); tick();
    drive(2'b11, 32'h11, 32'hFFFF_FFCC);
    expect_val(32'hAABB_3344); chk("sb_cycle_old", readdata); tick();
    rd("lw_final", 32'h10, 32'hAABB_CC44);
    rd("lw_unaligned", 32'h13, 32'hAABB_CC44);
    rd("lw_alias", 32'h410, 32'hAABB_CC44);
    drive(2'b11, 32'h13, 32'hFFFF_FF77); tick();
    drive(2'b10, 32'h11, 32'hFFFF_1234); tick();
    rd("lane3_half_low", 32'h10, 32'h77BB_1234);

    // Read-during-write
    drive(2'b01, 32'h20, 32'h0102_0304); tick();
    drive(2'b01, 32'h20, 32'hDEAD_BEEF);
    expect_val(32'h0102_0304); chk("rdw_old", readdata); tick();
    rd("rdw_new", 32'h20, 32'hDEAD_BEEF);
    drive(2'b01, 32'h40, 32'h1234_5678); tick();

    // FIFO fill and overflow
    for (int unsigned i = 1; i <= 8; i++) tx_store(8'(i));
    rd("status_full", A_ST, 32'h0000_0801);
    expect_val(32'h1); chk("full_tx_valid", {31'h0, tx_valid});
    expect_val(32'h1); chk("full_tx_head", {24'h0, tx_data});
    tick();
    tx_store(8'd9);
    rd("status_ovf", A_ST, 32'h0000_0805);
    tick();
    drain(txq.size());
    rd("status_drained", A_ST, st_exp());
    tick();
    drive(2'b01, A_ST, 32'h0000_0004); tick();
    m_ovf = 1'b0;
    rd("status_ovf_clr", A_ST, 32'h0000_0002);
    tick();

    // Push and pop while full
    for (int unsigned i = 0; i < 8; i++) tx_store(8'(8'h10 + i));
    tx_ready = 1'b1;
    tx_store(8'h55);
    tx_ready = 1'b0;
    rd("pp_status", A_ST, 32'h0000_0801);
    tick();
    drain(txq.size());

    // Cycle counter load and wrap
    drive(2'b01, A_CYC, 32'hFFFF_FFFE); tick();
    rd("cyc_load", A_CYC, 32'hFFFF_FFFE); tick();
    rd("cyc_max", A_CYC, 32'hFFFF_FFFF); tick();
    rd("cyc_wrap", A_CYC, 32'h0); tick();
    drive(2'b10, A_CYC, 32'h0001_2345); tick();
    rd("cyc_half_load", A_CYC, 32'h0001_2345);
    drive(2'b01, 32'hFFFF_000C, 32'hFFFF_FFFF); tick();
    rd("hole_write_ignored", A_ST, st_exp());
    tick();

    // Reset mid-drain
    for (int unsigned i = 1; i <= 9; i++) tx_store(8'(8'hA0 + i));
    drain(5);
    rd("pre_rst_status", A_ST, 32'h0000_0304);
    drive(2'b01, A_ST, 32'hFFFF_FFFB); tick();
    rd("ovf_not_cleared", A_ST, 32'h0000_0304);
    reset = 1'b1;
    drive(2'b01, 32'h40, 32'hFFFF_FFFF);
    tick();
    reset = 1'b0;
    txq.delete();
    m_ovf = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    expect_val(32'h0); chk("mid_rst_tx_valid", {31'h0, tx_valid});
    expect_val(32'h0); chk("mid_rst_tx_data", {24'h0, tx_data});
    rd("mid_rst_status", A_ST, 32'h0000_0002);
    rd("mid_rst_cycle", A_CYC, 32'h0);
    rd("store_during_reset", 32'h40, 32'h1234_5678);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
